// File: rtl/tiny_cpu_sequencer_pkg.sv
// Shared TinyCPU definitions: instruction width, opcodes, the NOP word and
// the sequencer state encoding.
package tiny_cpu_pkg;

  localparam int IW = 12;

  localparam logic [3:0] OP_CLR  = 4'b0000;
  localparam logic [3:0] OP_WRA  = 4'b0001;
  localparam logic [3:0] OP_WRB  = 4'b0010;
  localparam logic [3:0] OP_MOVB = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [IW-1:0] NOP_WORD = {OP_NOP, 8'h00};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/tiny_cpu_sequencer_if.sv
// Host-side bus of the program sequencer; Step exists only when
// TINY_SEQ_STEP_EN is defined.
interface tiny_seq_if
  import tiny_cpu_pkg::*;
#(
  parameter int AW = 4
);

  logic          Load_valid;
  logic [AW-1:0] Load_addr;
  logic [IW-1:0] Load_data;
  logic          Load_ready;
  logic [AW:0]   Prog_len;
  logic          Start;
  logic          Abort;
`ifdef TINY_SEQ_STEP_EN
  logic          Step;
`endif
  logic [IW-1:0] Instr;
  logic          Instr_valid;
  logic [AW-1:0] Pc;
  logic          Busy;
  logic          Done;

  modport master (
`ifdef TINY_SEQ_STEP_EN
    output Step,
`endif
    output Load_valid, Load_addr, Load_data, Prog_len, Start, Abort,
    input  Load_ready, Instr, Instr_valid, Pc, Busy, Done
  );

  modport slave (
`ifdef TINY_SEQ_STEP_EN
    input  Step,
`endif
    input  Load_valid, Load_addr, Load_data, Prog_len, Start, Abort,
    output Load_ready, Instr, Instr_valid, Pc, Busy, Done
  );

endinterface

// File: rtl/tiny_cpu_sequencer_progmem.sv
// Program buffer: DEPTH x IW register file, synchronous write, asynchronous
// read. Contents are deliberately not reset.
module tiny_seq_progmem
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);

  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Program sequencer feeding the TinyCPU instruction input, one word per HOLD
// cycles. Optional macro TINY_SEQ_STEP_EN adds a Step input gating each advance.
module tiny_cpu_sequencer
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int HOLD  = 4
) (
  input logic     Clk,
  input logic     Rst_n,
  tiny_seq_if.slave bus
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);

  seq_state_e    r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [HW-1:0] r_holdCnt;
  logic [IW-1:0] r_instr;
  logic          r_instrValid;
  logic [AW-1:0] r_pcOut;
  logic          r_busy;
  logic          r_done;

  logic          w_loadEn;
  logic [IW-1:0] w_word;
  logic          w_isHalt;
  logic          w_lastPc;
  logic          w_advance;
  logic [AW:0]   w_clampLen;

  assign w_loadEn   = bus.Load_valid && !r_busy;
  assign w_isHalt   = (w_word[IW-1 -: 4] == OP_HALT);
  assign w_lastPc   = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_clampLen = (bus.Prog_len > DEPTH_W) ? DEPTH_W : bus.Prog_len;
`ifdef TINY_SEQ_STEP_EN
  assign w_advance  = (r_holdCnt == HOLD_LAST) && bus.Step;
`else
  assign w_advance  = (r_holdCnt == HOLD_LAST);
`endif

  tiny_seq_progmem #(.DEPTH(DEPTH), .AW(AW)) u_progmem (
    .Clk     (Clk),
    .i_we    (w_loadEn),
    .i_waddr (bus.Load_addr),
    .i_wdata (bus.Load_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  // Outputs trail the state by one edge, so Pc reports the address whose
  // word is currently on Instr rather than the read pointer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_len        <= '0;
      r_holdCnt    <= '0;
      r_instr      <= NOP_WORD;
      r_instrValid <= 1'b0;
      r_pcOut      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (bus.Abort) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_holdCnt    <= '0;
      r_instr      <= NOP_WORD;
      r_instrValid <= 1'b0;
      r_pcOut      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_instr      <= NOP_WORD;
          r_instrValid <= 1'b0;
          r_pcOut      <= '0;
          if (bus.Start) begin
            r_len     <= w_clampLen;
            r_pc      <= '0;
            r_holdCnt <= '0;
            if (w_clampLen != '0) begin
              r_state <= ISSUE;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
            end
          end
        end
        ISSUE: begin
          r_pcOut <= r_pc;
          // A HALT word ends the run without ever reaching the CPU.
          if (w_isHalt) begin
            r_instr      <= NOP_WORD;
            r_instrValid <= 1'b0;
            r_state      <= DONE;
          end else begin
            r_instr      <= w_word;
            r_instrValid <= 1'b1;
            if (w_advance) begin
              r_holdCnt <= '0;
              if (w_lastPc) r_state <= DONE;
              else          r_pc    <= r_pc + 1'b1;
            end else if (r_holdCnt != HOLD_LAST) begin
              r_holdCnt <= r_holdCnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_done       <= 1'b1;
          r_instr      <= NOP_WORD;
          r_instrValid <= 1'b0;
          r_pc         <= '0;
          r_pcOut      <= '0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Load_ready  = !r_busy;
  assign bus.Instr       = r_instr;
  assign bus.Instr_valid = r_instrValid;
  assign bus.Pc          = r_pcOut;
  assign bus.Busy        = r_busy;
  assign bus.Done        = r_done;

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Scoreboard bench for tiny_cpu_sequencer: stimulus queues expected issue
// samples and Done pulses, a negedge monitor pops and compares them.
module tb_tiny_cpu_sequencer;
  import tiny_cpu_pkg::*;

  localparam int HOLD = 4;
  localparam int DEPTH = 16;

  typedef struct {
    bit          isDone;
    logic [11:0] instr;
    logic [3:0]  pc;
    int          cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t expQ[$];
  logic [11:0] progModel [DEPTH];

  tiny_seq_if #(.AW(4)) bus ();

  tiny_cpu_sequencer #(.DEPTH(DEPTH), .AW(4), .HOLD(HOLD)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every Instr_valid or Done sample must match the queue head.
  always @(negedge Clk) begin
    if (bus.Instr_valid === 1'b1 || bus.Done === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected output: Instr=0x%0h valid=%0b Done=%0b Pc=%0d, expected nothing (cycle %0d)",
                 bus.Instr, bus.Instr_valid, bus.Done, bus.Pc, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (e.isDone) begin
          checkOutput("donePulse", 32'(bus.Done), 32'd1);
          checkOutput("doneCycle", 32'(cyc), 32'(e.cyc));
        end else begin
          checkOutput("instrValid", 32'(bus.Instr_valid), 32'd1);
          checkOutput("instrWord", 32'(bus.Instr), 32'(e.instr));
          checkOutput("instrPc", 32'(bus.Pc), 32'(e.pc));
          checkOutput("instrCycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Expected run from the Start edge sc: word k held HOLD cycles starting one
  // cycle after sc; HALT ends the run; limit>=0 truncates with no Done.
  task automatic expectRun(input int sc, input int len, input int limit);
    int n = 0;
    int eff = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < eff; k++) begin
      logic [11:0] w;
      w = progModel[k];
      if (w[11:8] == OP_HALT) begin
        if (limit < 0) expQ.push_back(exp_t'{1'b1, 12'h000, 4'd0, sc + HOLD*k + 2});
        return;
      end
      for (int h = 0; h < HOLD; h++) begin
        if (n == limit) return;
        expQ.push_back(exp_t'{1'b0, w, 4'(k), sc + 1 + HOLD*k + h});
        n++;
      end
    end
    if (limit < 0) expQ.push_back(exp_t'{1'b1, 12'h000, 4'd0, sc + HOLD*eff + 1});
  endtask

  task automatic loadWord(input int addr, input logic [11:0] data);
    @(negedge Clk);
    bus.Load_valid = 1'b1;
    bus.Load_addr  = 4'(addr);
    bus.Load_data  = data;
    progModel[addr] = data;
    @(negedge Clk);
    bus.Load_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input int limit, output int sc);
    @(negedge Clk);
    bus.Prog_len = 5'(len);
    bus.Start    = 1'b1;
    sc = cyc + 1;
    expectRun(sc, len, limit);
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic drainCheck(input int cycles, input string name);
    repeat (cycles) @(negedge Clk);
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    int sc;
    logic [11:0] prog [8];
    prog = '{12'h000, 12'h107, 12'h208, 12'h400, 12'h900, 12'hB00, 12'h600, 12'h300};

    bus.Load_valid = 1'b0;
    bus.Load_addr  = '0;
    bus.Load_data  = '0;
    bus.Prog_len   = '0;
    bus.Start      = 1'b0;
    bus.Abort      = 1'b0;
`ifdef TINY_SEQ_STEP_EN
    bus.Step       = 1'b1;
`endif
    for (int i = 0; i < DEPTH; i++) progModel[i] = 12'hXXX;

    #12;
    checkOutput("rstInstr", 32'(bus.Instr), 32'h0F00);
    checkOutput("rstValid", 32'(bus.Instr_valid), 32'd0);
    checkOutput("rstPc", 32'(bus.Pc), 32'd0);
    checkOutput("rstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("rstDone", 32'(bus.Done), 32'd0);
    checkOutput("rstLoadReady", 32'(bus.Load_ready), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 8; i++) loadWord(i, prog[i]);

    $display("[TB] 8-word program run");
    applyStimulus(8, -1, sc);
    drainCheck(40, "runQueueEmpty");

    $display("[TB] reset in the middle of ISSUE");
    applyStimulus(8, 9, sc);
    repeat (9) @(negedge Clk);
    checkOutput("preResetPc", 32'(bus.Pc), 32'd2);
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("midRstInstr", 32'(bus.Instr), 32'h0F00);
    checkOutput("midRstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("midRstPc", 32'(bus.Pc), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    drainCheck(3, "resetQueueEmpty");
    applyStimulus(8, -1, sc);
    drainCheck(40, "rerunQueueEmpty");

    $display("[TB] HALT at word 3");
    loadWord(3, 12'hE00);
    applyStimulus(8, -1, sc);
    repeat (13) @(negedge Clk);
    checkOutput("haltValid", 32'(bus.Instr_valid), 32'd0);
    checkOutput("haltPc", 32'(bus.Pc), 32'd3);
    checkOutput("haltInstr", 32'(bus.Instr), 32'h0F00);
    drainCheck(40, "haltQueueEmpty");
    loadWord(3, 12'h400);

    $display("[TB] Abort with Start at Pc 5");
    applyStimulus(8, 21, sc);
    repeat (21) @(negedge Clk);
    checkOutput("preAbortPc", 32'(bus.Pc), 32'd5);
    bus.Abort = 1'b1;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    bus.Start = 1'b0;
    checkOutput("abortInstr", 32'(bus.Instr), 32'h0F00);
    checkOutput("abortValid", 32'(bus.Instr_valid), 32'd0);
    checkOutput("abortPc", 32'(bus.Pc), 32'd0);
    checkOutput("abortBusy", 32'(bus.Busy), 32'd0);
    checkOutput("abortDone", 32'(bus.Done), 32'd0);
    drainCheck(40, "abortQueueEmpty");

    $display("[TB] load while busy, then zero-length run");
    applyStimulus(2, -1, sc);
    bus.Load_valid = 1'b1;
    bus.Load_addr  = 4'd0;
    bus.Load_data  = 12'h123;
    checkOutput("busyLoadReady", 32'(bus.Load_ready), 32'd0);
    checkOutput("busyFlag", 32'(bus.Busy), 32'd1);
    @(negedge Clk);
    bus.Load_valid = 1'b0;
    drainCheck(15, "busyRunQueueEmpty");
    applyStimulus(1, -1, sc);
    drainCheck(10, "word0QueueEmpty");
    applyStimulus(0, -1, sc);
    drainCheck(6, "zeroLenQueueEmpty");

    $display("[TB] load and Start in the same cycle");
    @(negedge Clk);
    bus.Load_valid = 1'b1;
    bus.Load_addr  = 4'd0;
    bus.Load_data  = 12'h321;
    progModel[0]   = 12'h321;
    bus.Prog_len   = 5'd1;
    bus.Start      = 1'b1;
    sc = cyc + 1;
    expectRun(sc, 1, -1);
    @(negedge Clk);
    bus.Load_valid = 1'b0;
    bus.Start      = 1'b0;
    drainCheck(10, "sameCycleQueueEmpty");

    $display("[TB] Prog_len above DEPTH clamps to 16");
    for (int i = 8; i < DEPTH; i++) loadWord(i, 12'h1A0 + 12'(i));
    applyStimulus(20, -1, sc);
    drainCheck(75, "clampQueueEmpty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_sequencer.md
Name: tiny_cpu_sequencer

Overview:
- Program sequencer that feeds the TinyCPU's 12-bit instruction input.
- Holds a small program buffer loaded through a write port.
- On Start, issues the stored instructions in order, each held for a fixed number of Clk cycles, then signals Done.
- Sits between the host/testbench and the TinyCPU `In` port, replacing hand-timed instruction streams.

Parameters:
- DEPTH, 16, number of program buffer entries.
- AW, 4, program address width; log2(DEPTH).
- IW, 12, instruction width; matches the TinyCPU `In` port.
- HOLD, 4, Clk cycles each instruction is driven on Instr (≥1).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Load_valid  input  1  write Load_data into buffer[Load_addr] this cycle.
- Load_addr  input  AW  program buffer write address.
- Load_data  input  IW  instruction to store.
- Load_ready  output  1  high when loads are accepted (= !Busy).
- Prog_len  input  AW+1  number of instructions to run (0..DEPTH); sampled on Start.
- Start  input  1  begin execution from address 0.
- Abort  input  1  stop execution immediately.
- Instr  output  IW  instruction to TinyCPU `In`.
- Instr_valid  output  1  high while Instr carries a program instruction.
- Pc  output  AW  address of the instruction being issued.
- Busy  output  1  high in ISSUE.
- Done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Constants:
  - NOP = 12'hF00 (opcode 4'b1111, reserved, no effect on the CPU).
  - HALT opcode = 4'b1110.
  - Opcode 0000 is "clear all" and is never driven while idle.
- Reset (async, Rst_n low): state IDLE; Instr=NOP; Instr_valid=0; Pc=0; Busy=0; Done=0; hold counter=0. Buffer contents are not reset.
- IDLE:
  - Instr=NOP.
  - Load_valid writes the buffer at the clock edge.
  - Start with Prog_len>0 → ISSUE next cycle. Latch len=Prog_len, set Pc=0, hold counter=0.
  - Start with Prog_len=0 → DONE next cycle.
  - Start and Load_valid in the same cycle: the load completes first, so the new entry is visible at Pc 0.
- ISSUE:
  - Instr=buffer[Pc]; Instr_valid=1; Busy=1; Load_valid ignored.
  - Hold counter counts 0..HOLD-1; at HOLD-1 it clears.
  - If Pc==len-1 → DONE; else Pc increments.
  - If buffer[Pc][IW-1:IW-4]==HALT: Instr=NOP, Instr_valid=0, next cycle DONE. HALT is never issued.
  - Start while Busy is ignored.
- DONE:
  - One cycle: Done=1, Instr=NOP, Instr_valid=0.
  - Next state IDLE with Pc=0.
- Abort (any state, highest priority after reset): next cycle IDLE with Pc=0, Instr=NOP, no Done pulse. Abort and Start in the same cycle: Abort wins.
- Latency: Start at edge N → first instruction on Instr after edge N+1. Total run = len·HOLD + 1 (DONE) cycles after Start.
- Pc never wraps: len ≤ DEPTH. Prog_len > DEPTH is clamped to DEPTH.
- All outputs are registered except Load_ready.

Optional Feature:
- Macro: TINY_SEQ_STEP_EN.
- Defined:
  - Adds input Step (1 bit).
  - In ISSUE, after the hold counter reaches HOLD-1, the sequencer holds the current instruction until a cycle with Step=1, then advances as normal.
  - Abort still overrides.
- Undefined: no Step port; advance is free-running every HOLD cycles.

Decomposition:
- Package tiny_cpu_pkg:
  - IW.
  - Opcode constants (OP_CLR=0000, OP_WRA=0001, OP_WRB=0010, OP_MOVB=0011, OP_ADD=0100, OP_SHR=0110, OP_XOR=1001, OP_CMP=1011, OP_HALT=1110, OP_NOP=1111).
  - NOP word.
  - Sequencer state enum {IDLE, ISSUE, DONE}.
- One sub-module, tiny_seq_progmem: DEPTH×IW register-file buffer, with one sync write port and one async read port.

Test Plan:
- Reset mid-ISSUE at Pc=2 → same cycle: Instr=12'hF00, Busy=0, Pc=0. Buffer contents unchanged on rerun.
- Run 8-word program:
  - Program: 000000000000, 000100000111, 001000001000, 010000000000, 100100000000, 101100000000, 011000000000, 001100000000.
  - HOLD=4, Prog_len=8, pulse Start.
  - Required: each word on Instr for exactly 4 cycles in order; Done pulse 33 cycles after Start; TinyCPU Result=8'b00000011.
- HALT test: word 3 = 12'hE00, Prog_len=8 → words 0–2 issued, Instr_valid low at Pc=3, Done next cycle, words 4–7 never appear.
- Abort at Pc=5 with Start in the same cycle → IDLE next cycle, Instr=NOP, no Done pulse, Start ignored.
- Load while Busy (Load_addr=0, Load_data=12'h123) → buffer[0] unchanged, Load_ready=0. Prog_len=0 with Start → Done one cycle later, no Instr_valid.
- TINY_SEQ_STEP_EN defined, Step held low → Pc stays 0 and Instr stays at word 0. One Step pulse → Pc=1 on the next cycle.
